// File: rtl/mul_arbiter_taint.sv
// mul_arbiter_taint
//
// Round-robin arbiter that shares one variable-latency multiplier between two
// requesters. A request is accepted in IDLE, issued to the multiplier for one
// cycle (ISSUE), waited on (WAIT), and the captured product is returned as a
// one-cycle pulse on the response port of the requester that issued it (RESP).
// Only one operation is outstanding at a time.
//
// Every control and data signal carries a 1-bit taint shadow (suffix _t) with
// conservative, sticky propagation. Taint state is cleared only by rst. This
// lets information-flow checkers see when grant or response timing depends on
// tainted inputs.
//
// Parameters:
//   WIDTH    operand width; products are 2*WIDTH bits wide
//   TIMEOUT  maximum number of WAIT cycles (only with MUL_ARB_TIMEOUT_EN)
//
// Ports:
//   clk, rst                          clock; synchronous active-high reset
//   reqN_valid/_t, reqN_a/_t,
//   reqN_b/_t                         request N (N=0,1) with operands + taints
//   reqN_ready/_t                     combinational accept, only in IDLE
//   mul_in_valid/_t                   one-cycle issue pulse to the multiplier
//   mul_in_a/_t, mul_in_b/_t          operands, held from ISSUE through RESP
//   mul_out_valid/_t                  multiplier done
//   mul_out_result/_t                 multiplier product
//   respN_valid/_t, respN_result/_t   one-cycle response to requester N;
//                                     result reads 0 when valid is low
//
// Optional feature (define MUL_ARB_TIMEOUT_EN):
//   A 5-bit counter bounds WAIT to TIMEOUT cycles. On expiry the arbiter
//   responds with result 0 and raises respN_err alongside respN_valid.
//   Adds ports respN_err/respN_err_t. Without the macro WAIT is unbounded.

module mul_arbiter_taint #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               req0_valid,
    input  logic               req0_valid_t,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic               req0_a_t,
    input  logic [WIDTH-1:0]   req0_b,
    input  logic               req0_b_t,
    output logic               req0_ready,
    output logic               req0_ready_t,

    input  logic               req1_valid,
    input  logic               req1_valid_t,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic               req1_a_t,
    input  logic [WIDTH-1:0]   req1_b,
    input  logic               req1_b_t,
    output logic               req1_ready,
    output logic               req1_ready_t,

    output logic               mul_in_valid,
    output logic               mul_in_valid_t,
    output logic [WIDTH-1:0]   mul_in_a,
    output logic               mul_in_a_t,
    output logic [WIDTH-1:0]   mul_in_b,
    output logic               mul_in_b_t,
    input  logic               mul_out_valid,
    input  logic               mul_out_valid_t,
    input  logic [2*WIDTH-1:0] mul_out_result,
    input  logic               mul_out_result_t,

    output logic               resp0_valid,
    output logic               resp0_valid_t,
    output logic [2*WIDTH-1:0] resp0_result,
    output logic               resp0_result_t,

    output logic               resp1_valid,
    output logic               resp1_valid_t,
    output logic [2*WIDTH-1:0] resp1_result,
    output logic               resp1_result_t
`ifdef MUL_ARB_TIMEOUT_EN
    ,
    output logic               resp0_err,
    output logic               resp0_err_t,
    output logic               resp1_err,
    output logic               resp1_err_t
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic               rr_ptr;
    logic               gnt_id;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [2*WIDTH-1:0] res;

    logic               ctrl_t;
    logic               op_a_t;
    logic               op_b_t;
    logic               res_t;

    logic               any_req;
    logic               any_valid_t;
    logic               gnt_sel;
    logic               accept;
    logic               capture;

`ifdef MUL_ARB_TIMEOUT_EN
    // WAIT lasts TIMEOUT cycles: the counter reads 0 in the first WAIT cycle,
    // so expiry is detected when it reads TIMEOUT-1.
    localparam logic [4:0] WAIT_LAST = 5'(TIMEOUT - 1);

    logic [4:0]         wait_cnt;
    logic               timeout_hit;
    logic               timed_out;
`endif

    // Arbitration. With both requesters valid rr_ptr breaks the tie; with a
    // single requester valid that requester wins. Ready is suppressed while
    // rst is high so nothing looks accepted during a reset cycle.
    always_comb begin
        any_req     = req0_valid | req1_valid;
        any_valid_t = req0_valid_t | req1_valid_t;
        gnt_sel     = (req0_valid & req1_valid) ? rr_ptr : req1_valid;
        req0_ready  = (state == IDLE) & ~rst & req0_valid & ~gnt_sel;
        req1_ready  = (state == IDLE) & ~rst & req1_valid &  gnt_sel;
        accept      = req0_ready | req1_ready;
    end

    // Next-state logic for the IDLE -> ISSUE -> WAIT -> RESP loop.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
`ifdef MUL_ARB_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                // A done in the same cycle as expiry wins: normal response.
                if (mul_out_valid) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
`ifdef MUL_ARB_TIMEOUT_EN
                else if (wait_cnt == WAIT_LAST) begin
                    timeout_hit = 1'b1;
                    state_nxt   = RESP;
                end
`endif
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, operand, result and taint registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= 1'b0;
            gnt_id <= 1'b0;
            op_a   <= '0;
            op_b   <= '0;
            res    <= '0;
            ctrl_t <= 1'b0;
            op_a_t <= 1'b0;
            op_b_t <= 1'b0;
            res_t  <= 1'b0;
        end else begin
            state <= state_nxt;

            // The grant decision leaks request-valid taint; the WAIT exit
            // timing leaks the multiplier's done taint. Both stick.
            ctrl_t <= ctrl_t
                    | ((state == IDLE) & any_req & any_valid_t)
                    | ((state == WAIT) & mul_out_valid_t);

            if (accept) begin
                gnt_id <= gnt_sel;
                op_a   <= gnt_sel ? req1_a : req0_a;
                op_b   <= gnt_sel ? req1_b : req0_b;
                // Which requester's operands got latched depends on both
                // valids, so their taints fold into the operand taints.
                op_a_t <= (gnt_sel ? req1_a_t : req0_a_t) | any_valid_t;
                op_b_t <= (gnt_sel ? req1_b_t : req0_b_t) | any_valid_t;
            end

            if (capture) begin
                res   <= mul_out_result;
                res_t <= res_t | mul_out_result_t | ctrl_t;
            end
`ifdef MUL_ARB_TIMEOUT_EN
            else if (timeout_hit) begin
                res   <= '0;
                res_t <= res_t | ctrl_t;
            end
`endif

            // Served requester loses the next tie.
            if (state == RESP) begin
                rr_ptr <= ~gnt_id;
            end
        end
    end

`ifdef MUL_ARB_TIMEOUT_EN
    // WAIT cycle counter and the error flag reported with the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt  <= '0;
            timed_out <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 5'd1;
            end

            if (accept || capture) begin
                timed_out <= 1'b0;
            end else if (timeout_hit) begin
                timed_out <= 1'b1;
            end
        end
    end
`endif

    // Output decode. Results are forced to 0 outside the response pulse.
    always_comb begin
        req0_ready_t   = ctrl_t | any_valid_t;
        req1_ready_t   = ctrl_t | any_valid_t;

        mul_in_valid   = (state == ISSUE);
        mul_in_valid_t = ctrl_t;
        mul_in_a       = op_a;
        mul_in_a_t     = op_a_t;
        mul_in_b       = op_b;
        mul_in_b_t     = op_b_t;

        resp0_valid    = (state == RESP) & ~gnt_id;
        resp1_valid    = (state == RESP) &  gnt_id;
        resp0_result   = resp0_valid ? res : '0;
        resp1_result   = resp1_valid ? res : '0;
        resp0_valid_t  = ctrl_t;
        resp1_valid_t  = ctrl_t;
        resp0_result_t = res_t | ctrl_t;
        resp1_result_t = res_t | ctrl_t;
`ifdef MUL_ARB_TIMEOUT_EN
        resp0_err      = resp0_valid & timed_out;
        resp1_err      = resp1_valid & timed_out;
        resp0_err_t    = ctrl_t;
        resp1_err_t    = ctrl_t;
`endif
    end

endmodule

// File: tb/tb_mul_arbiter_taint.sv
// tb_mul_arbiter_taint
//
// Bench for mul_arbiter_taint. Contains a behavioural multiplier with a
// two-cycle latency and a one-cycle path when either live operand is zero.
// A table of single transactions and hand-written sequences (round-robin,
// reset during WAIT, taint, optional timeout) are followed by a randomized
// phase checked against a transaction-level timing model.

module tb_mul_arbiter_taint;

    localparam int WIDTH   = 4;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic             req0_valid   = 1'b0;
    logic             req0_valid_t = 1'b0;
    logic [WIDTH-1:0] req0_a       = '0;
    logic             req0_a_t     = 1'b0;
    logic [WIDTH-1:0] req0_b       = '0;
    logic             req0_b_t     = 1'b0;
    logic             req0_ready;
    logic             req0_ready_t;

    logic             req1_valid   = 1'b0;
    logic             req1_valid_t = 1'b0;
    logic [WIDTH-1:0] req1_a       = '0;
    logic             req1_a_t     = 1'b0;
    logic [WIDTH-1:0] req1_b       = '0;
    logic             req1_b_t     = 1'b0;
    logic             req1_ready;
    logic             req1_ready_t;

    logic               mul_in_valid;
    logic               mul_in_valid_t;
    logic [WIDTH-1:0]   mul_in_a;
    logic               mul_in_a_t;
    logic [WIDTH-1:0]   mul_in_b;
    logic               mul_in_b_t;
    logic               mul_out_valid;
    logic               mul_out_valid_t;
    logic [2*WIDTH-1:0] mul_out_result;
    logic               mul_out_result_t;

    logic               resp0_valid;
    logic               resp0_valid_t;
    logic [2*WIDTH-1:0] resp0_result;
    logic               resp0_result_t;
    logic               resp1_valid;
    logic               resp1_valid_t;
    logic [2*WIDTH-1:0] resp1_result;
    logic               resp1_result_t;
`ifdef MUL_ARB_TIMEOUT_EN
    logic               resp0_err;
    logic               resp0_err_t;
    logic               resp1_err;
    logic               resp1_err_t;
`endif

    int checks = 0;
    int errors = 0;

    logic mul_stall = 1'b0;
    logic mul_busy;
    logic mul_rem;

    mul_arbiter_taint #(
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req0_valid       (req0_valid),
        .req0_valid_t     (req0_valid_t),
        .req0_a           (req0_a),
        .req0_a_t         (req0_a_t),
        .req0_b           (req0_b),
        .req0_b_t         (req0_b_t),
        .req0_ready       (req0_ready),
        .req0_ready_t     (req0_ready_t),
        .req1_valid       (req1_valid),
        .req1_valid_t     (req1_valid_t),
        .req1_a           (req1_a),
        .req1_a_t         (req1_a_t),
        .req1_b           (req1_b),
        .req1_b_t         (req1_b_t),
        .req1_ready       (req1_ready),
        .req1_ready_t     (req1_ready_t),
        .mul_in_valid     (mul_in_valid),
        .mul_in_valid_t   (mul_in_valid_t),
        .mul_in_a         (mul_in_a),
        .mul_in_a_t       (mul_in_a_t),
        .mul_in_b         (mul_in_b),
        .mul_in_b_t       (mul_in_b_t),
        .mul_out_valid    (mul_out_valid),
        .mul_out_valid_t  (mul_out_valid_t),
        .mul_out_result   (mul_out_result),
        .mul_out_result_t (mul_out_result_t),
        .resp0_valid      (resp0_valid),
        .resp0_valid_t    (resp0_valid_t),
        .resp0_result     (resp0_result),
        .resp0_result_t   (resp0_result_t),
        .resp1_valid      (resp1_valid),
        .resp1_valid_t    (resp1_valid_t),
        .resp1_result     (resp1_result),
        .resp1_result_t   (resp1_result_t)
`ifdef MUL_ARB_TIMEOUT_EN
        ,
        .resp0_err        (resp0_err),
        .resp0_err_t      (resp0_err_t),
        .resp1_err        (resp1_err),
        .resp1_err_t      (resp1_err_t)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural multiplier: done two cycles after the issue pulse, or one
    // cycle after it when either live operand is zero. Shares rst.
    always @(posedge clk) begin
        if (rst) begin
            mul_busy <= 1'b0;
            mul_rem  <= 1'b0;
        end else if (mul_in_valid) begin
            mul_busy <= 1'b1;
            mul_rem  <= (mul_in_a != 0) && (mul_in_b != 0);
        end else if (mul_busy) begin
            if (!mul_rem) mul_busy <= 1'b0;
            mul_rem <= 1'b0;
        end
    end

    assign mul_out_valid    = mul_busy && !mul_rem && !mul_stall;
    assign mul_out_valid_t  = 1'b0;
    assign mul_out_result   = {4'b0, mul_in_a} * {4'b0, mul_in_b};
    assign mul_out_result_t = mul_in_a_t | mul_in_b_t;

    typedef struct {
        logic       port;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] result;
        int         lat;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v0, input logic [3:0] a0, input logic [3:0] b0,
                                 input logic v1, input logic [3:0] a1, input logic [3:0] b1);
        req0_valid = v0;
        req0_a     = a0;
        req0_b     = b0;
        req1_valid = v1;
        req1_a     = a1;
        req1_b     = b1;
    endtask

    task automatic clearTaint();
        req0_valid_t = 1'b0;
        req0_a_t     = 1'b0;
        req0_b_t     = 1'b0;
        req1_valid_t = 1'b0;
        req1_a_t     = 1'b0;
        req1_b_t     = 1'b0;
    endtask

    task automatic doReset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input string what,
                               input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s/%s: got %0h, expected %0h", tag, what, actual, expected);
        end
    endtask

    // Walks one transaction from its accept cycle (inputs already driven) to
    // its response cycle, checking every cycle along the way.
    task automatic runTxn(input string tag, input logic port, input logic [7:0] result,
                          input int lat, input bit hold);
        for (int k = 0; k <= lat; k++) begin
            #1;
            checkOutput(tag, "ready", 32'({req1_ready, req0_ready}),
                        (k == 0) ? (port ? 32'd2 : 32'd1) : 32'd0);
            checkOutput(tag, "mul_in_valid", 32'(mul_in_valid), 32'(k == 1));
            checkOutput(tag, "resp_valid", 32'({resp1_valid, resp0_valid}),
                        (k == lat) ? (port ? 32'd2 : 32'd1) : 32'd0);
            checkOutput(tag, "resp_result", 32'({resp1_result, resp0_result}),
                        (k == lat) ? (port ? 32'({result, 8'h00}) : 32'(result)) : 32'd0);
`ifdef MUL_ARB_TIMEOUT_EN
            checkOutput(tag, "resp_err", 32'({resp1_err, resp0_err}), 32'd0);
`endif
            tick();
            if (k == 0 && !hold) applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        vec_t vecs[7];
        logic       h0, h1;
        logic [3:0] ra0, rb0, ra1, rb1, ga, gb;
        logic [1:0] exp_rdy;
        logic       resp_port;
        logic [7:0] resp_val;
        int         busy_until, rr, acc_cyc, resp_cyc, g;

        vecs[0] = '{1'b0, 4'd3,  4'd5,  8'd15,  4};
        vecs[1] = '{1'b1, 4'd0,  4'd7,  8'd0,   3};
        vecs[2] = '{1'b0, 4'd15, 4'd15, 8'd225, 4};
        vecs[3] = '{1'b1, 4'd6,  4'd0,  8'd0,   3};
        vecs[4] = '{1'b1, 4'd9,  4'd7,  8'd63,  4};
        vecs[5] = '{1'b0, 4'd0,  4'd0,  8'd0,   3};
        vecs[6] = '{1'b0, 4'd1,  4'd1,  8'd1,   4};

        // Reset state
        doReset(2);
        #1;
        checkOutput("reset", "ready", 32'({req1_ready, req0_ready}), 32'd0);
        checkOutput("reset", "mul_in_valid", 32'(mul_in_valid), 32'd0);
        checkOutput("reset", "mul_in_ops", 32'({mul_in_a, mul_in_b}), 32'd0);
        checkOutput("reset", "resp_valid", 32'({resp1_valid, resp0_valid}), 32'd0);
        checkOutput("reset", "resp_result", 32'({resp1_result, resp0_result}), 32'd0);
        checkOutput("reset", "taints", 32'({req0_ready_t, req1_ready_t, mul_in_valid_t,
                    mul_in_a_t, mul_in_b_t, resp0_valid_t, resp1_valid_t,
                    resp0_result_t, resp1_result_t}), 32'd0);
`ifdef MUL_ARB_TIMEOUT_EN
        checkOutput("reset", "err", 32'({resp0_err, resp1_err, resp0_err_t, resp1_err_t}), 32'd0);
`endif
        tick();

        // Single-transaction table
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].port)
                applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, vecs[i].a, vecs[i].b);
            else
                applyStimulus(1'b1, vecs[i].a, vecs[i].b, 1'b0, 4'd0, 4'd0);
            runTxn($sformatf("vec%0d", i), vecs[i].port, vecs[i].result, vecs[i].lat, 1'b0);
        end

        // Both requesters held valid: grants alternate starting from port 0
        doReset(1);
        applyStimulus(1'b1, 4'd2, 4'd2, 1'b1, 4'd3, 4'd3);
        runTxn("rr0", 1'b0, 8'd4, 4, 1'b1);
        runTxn("rr1", 1'b1, 8'd9, 4, 1'b1);
        runTxn("rr2", 1'b0, 8'd4, 4, 1'b1);
        runTxn("rr3", 1'b1, 8'd9, 4, 1'b0);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);

        // Reset while in WAIT aborts without a response
        applyStimulus(1'b1, 4'd3, 4'd5, 1'b0, 4'd0, 4'd0);
        #1;
        checkOutput("rst_wait", "accept", 32'(req0_ready), 32'd1);
        tick();
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checkOutput("rst_wait", "resp_valid", 32'({resp1_valid, resp0_valid}), 32'd0);
            checkOutput("rst_wait", "mul_in_valid", 32'(mul_in_valid), 32'd0);
            if (k == 0)
                checkOutput("rst_wait", "mul_in_ops", 32'({mul_in_a, mul_in_b}), 32'd0);
            tick();
        end
        applyStimulus(1'b1, 4'd3, 4'd5, 1'b0, 4'd0, 4'd0);
        runTxn("after_rst", 1'b0, 8'd15, 4, 1'b0);

        // Control taint: a tainted valid makes control taint stick until rst
        doReset(1);
        applyStimulus(1'b1, 4'd2, 4'd3, 1'b0, 4'd0, 4'd0);
        req0_valid_t = 1'b1;
        #1;
        checkOutput("taint_ctrl", "ready_t", 32'({req1_ready_t, req0_ready_t}), 32'd3);
        tick();
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
        clearTaint();
        #1;
        checkOutput("taint_ctrl", "mul_in_valid", 32'(mul_in_valid), 32'd1);
        checkOutput("taint_ctrl", "mul_in_valid_t", 32'(mul_in_valid_t), 32'd1);
        checkOutput("taint_ctrl", "op_t", 32'({mul_in_a_t, mul_in_b_t}), 32'd3);
        tick(); tick(); tick();
        #1;
        checkOutput("taint_ctrl", "resp0_valid", 32'(resp0_valid), 32'd1);
        checkOutput("taint_ctrl", "resp0_valid_t", 32'(resp0_valid_t), 32'd1);
        tick(); tick();
        #1;
        checkOutput("taint_ctrl", "sticky", 32'({req0_ready_t, mul_in_valid_t, resp0_valid_t}), 32'd7);
        doReset(1);
        #1;
        checkOutput("taint_ctrl", "cleared", 32'({req0_ready_t, mul_in_valid_t, resp0_valid_t,
                    resp0_result_t}), 32'd0);
        tick();

        // Data taint only: result taint set, control taint stays clear
        applyStimulus(1'b1, 4'd3, 4'd5, 1'b0, 4'd0, 4'd0);
        req0_a_t = 1'b1;
        runTxn("taint_data", 1'b0, 8'd15, 4, 1'b0);
        clearTaint();
        #1;
        checkOutput("taint_data", "resp0_result_t", 32'(resp0_result_t), 32'd1);
        checkOutput("taint_data", "resp0_valid_t", 32'(resp0_valid_t), 32'd0);
        checkOutput("taint_data", "op_t", 32'({mul_in_a_t, mul_in_b_t}), 32'd2);
        tick();

`ifdef MUL_ARB_TIMEOUT_EN
        // Stalled multiplier: response with err after TIMEOUT WAIT cycles
        doReset(1);
        mul_stall = 1'b1;
        applyStimulus(1'b1, 4'd3, 4'd5, 1'b0, 4'd0, 4'd0);
        for (int k = 0; k <= TIMEOUT + 2; k++) begin
            #1;
            if (k == 0) checkOutput("timeout", "ready", 32'(req0_ready), 32'd1);
            checkOutput("timeout", "resp0_valid", 32'(resp0_valid), 32'(k == TIMEOUT + 2));
            checkOutput("timeout", "resp0_err", 32'(resp0_err), 32'(k == TIMEOUT + 2));
            checkOutput("timeout", "resp0_result", 32'(resp0_result), 32'd0);
            tick();
            if (k == 0) applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
        end
        mul_stall = 1'b0;
`endif

        // Randomized traffic against a transaction-timing model
        doReset(1);
        h0 = 1'b0; h1 = 1'b0;
        ra0 = '0; rb0 = '0; ra1 = '0; rb1 = '0;
        busy_until = 0; rr = 0; acc_cyc = -10; resp_cyc = -1;
        resp_port = 1'b0; resp_val = '0;
        for (int c = 0; c < 400; c++) begin
            if (!h0) begin
                if ($urandom_range(0, 2) == 0) begin
                    h0 = 1'b1; ra0 = 4'($urandom); rb0 = 4'($urandom);
                    if ($urandom_range(0, 4) == 0) ra0 = 4'd0;
                end
            end else if ($urandom_range(0, 11) == 0) begin
                h0 = 1'b0;
            end
            if (!h1) begin
                if ($urandom_range(0, 2) == 0) begin
                    h1 = 1'b1; ra1 = 4'($urandom); rb1 = 4'($urandom);
                    if ($urandom_range(0, 4) == 0) rb1 = 4'd0;
                end
            end else if ($urandom_range(0, 11) == 0) begin
                h1 = 1'b0;
            end
            applyStimulus(h0, ra0, rb0, h1, ra1, rb1);

            exp_rdy = 2'b00;
            if (c >= busy_until && (h0 || h1)) begin
                g          = (h0 && h1) ? rr : (h1 ? 1 : 0);
                ga         = (g == 1) ? ra1 : ra0;
                gb         = (g == 1) ? rb1 : rb0;
                exp_rdy    = (g == 1) ? 2'b10 : 2'b01;
                acc_cyc    = c;
                resp_cyc   = c + ((ga == 0 || gb == 0) ? 3 : 4);
                busy_until = resp_cyc + 1;
                resp_port  = (g == 1);
                resp_val   = 8'(int'(ga) * int'(gb));
                rr         = 1 - g;
            end

            #1;
            checkOutput("random", "ready", 32'({req1_ready, req0_ready}), 32'(exp_rdy));
            checkOutput("random", "mul_in_valid", 32'(mul_in_valid), 32'(c == acc_cyc + 1));
            checkOutput("random", "resp_valid", 32'({resp1_valid, resp0_valid}),
                        (c == resp_cyc) ? (resp_port ? 32'd2 : 32'd1) : 32'd0);
            checkOutput("random", "resp_result", 32'({resp1_result, resp0_result}),
                        (c == resp_cyc) ? (resp_port ? 32'({resp_val, 8'h00}) : 32'(resp_val)) : 32'd0);
            tick();
            if (exp_rdy[0]) h0 = 1'b0;
            if (exp_rdy[1]) h1 = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_arbiter_taint.md
Name: mul_arbiter_taint

Overview:
- Round-robin arbiter that shares one variable-latency multiplier between two requesters.
- Sits between requester ports 0/1 and the multiplier's in_valid/in_a/in_b/out_valid/out_result interface. It returns each result to the requester that issued it.
- Carries 1-bit taint shadows on every control and data signal, with conservative sticky propagation, for information-flow checking of the grant and response timing.

Parameters:
- WIDTH, 4, operand width; the result is 2*WIDTH.
- TIMEOUT, 15, maximum WAIT cycles; used only with MUL_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- reqN_valid / reqN_valid_t  in  1/1  request from requester N (N=0,1) and its taint.
- reqN_a / reqN_a_t  in  WIDTH/1  operand A and its taint.
- reqN_b / reqN_b_t  in  WIDTH/1  operand B and its taint.
- reqN_ready / reqN_ready_t  out  1/1  accept pulse and its taint.
- mul_in_valid / mul_in_valid_t  out  1/1  issue to the multiplier.
- mul_in_a, mul_in_b / mul_in_a_t, mul_in_b_t  out  WIDTH/1  operands held to the multiplier.
- mul_out_valid / mul_out_valid_t  in  1/1  multiplier done.
- mul_out_result / mul_out_result_t  in  2*WIDTH/1  multiplier product.
- respN_valid / respN_valid_t  out  1/1  one-cycle response pulse to requester N.
- respN_result / respN_result_t  out  2*WIDTH/1  product returned to requester N.

Behaviour:
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. State is 2 bits.
- Registers: rr_ptr (1 bit), gnt_id (1 bit), op_a/op_b, res.
- Reset:
  - state=IDLE, rr_ptr=0, gnt_id=0, op_a=op_b=0, res=0.
  - All taint registers = 0.
  - All outputs 0: ready, mul_in_valid, resp_valid, resp_result.
  - The multiplier shares rst.
  - Reset mid-operation aborts the transaction and produces no response.
- IDLE arbitration:
  - Only req0 valid: grant 0. Only req1 valid: grant 1.
  - Both valid: grant rr_ptr.
  - reqN_ready is combinational and high only for the granted N, only in IDLE.
  - On valid&&ready: latch op_a/op_b and gnt_id, then go to ISSUE.
  - No request: stay in IDLE.
- ISSUE: mul_in_valid=1 for exactly one cycle, then go to WAIT.
- Operand hold: mul_in_a/mul_in_b are driven from op_a/op_b and held stable from ISSUE through RESP. The multiplier's done condition depends on its live operands (zero-operand fast path).
- WAIT: on mul_out_valid, capture res=mul_out_result and go to RESP. Otherwise stay in WAIT.
- RESP:
  - resp[gnt_id]_valid=1 for one cycle; resp[gnt_id]_result=res.
  - The other response port stays 0.
  - rr_ptr <= ~gnt_id. Go to IDLE.
  - resp*_result is 0 whenever resp*_valid is 0.
- Latency with MUL_LATENCY=2, accept in cycle T:
  - mul_in_valid in T+1.
  - Response in T+3 if either operand is 0, otherwise T+4.
- Throughput: at most one outstanding operation. The next accept is possible in the cycle after RESP.
- Requester rules: a requester holds valid and operands until ready. Dropping valid before ready is legal; nothing is latched.
- Taint (sticky, cleared only by rst):
  - ctrl_t <= ctrl_t | (IDLE && any reqN_valid && (req0_valid_t|req1_valid_t)) | (WAIT && mul_out_valid_t).
  - reqN_ready_t = ctrl_t | req0_valid_t | req1_valid_t.
  - On accept: op_a_t <= granted reqN_a_t | req0_valid_t | req1_valid_t. op_b_t follows the same rule.
  - mul_in_valid_t = ctrl_t. mul_in_a_t = op_a_t. mul_in_b_t = op_b_t.
  - On capture: res_t <= res_t | mul_out_result_t | ctrl_t.
  - respN_valid_t = ctrl_t. respN_result_t = res_t | ctrl_t.

Optional Feature:
- Macro: MUL_ARB_TIMEOUT_EN.
- Enabled:
  - A 5-bit wait counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without mul_out_valid, go to RESP with res=0.
  - Extra outputs respN_err/respN_err_t (1/1): respN_err=1 alongside respN_valid; respN_err_t=ctrl_t.
  - A mul_out_valid in the same cycle as the timeout takes priority, giving a normal response.
- Disabled: no counter and no err ports; WAIT is unbounded.

Test Plan:
- rst held 2 cycles, then req0 a=3,b=5 -> req0_ready in T, mul_in_valid in T+1, resp0_valid in T+4 with result 15; resp1_valid stays 0.
- req1 a=0,b=7 -> resp1_valid in T+3 with result 0 (fast path).
- Both requests valid continuously (req0 2x2, req1 3x3) -> grants alternate 0,1,0,1; results 4 and 9 go to the correct ports.
- rst asserted while in WAIT -> next cycle is IDLE, no resp pulse, all outputs 0; a fresh req0 afterwards completes normally.
- Taint checks:
  - req0_valid_t=1, operand taints 0 -> ready_t, mul_in_valid_t and resp0_valid_t are all 1 and stay 1 until rst.
  - Separately, only req0_a_t=1 -> resp0_result_t=1 and resp0_valid_t=0.
- MUL_ARB_TIMEOUT_EN with mul_out_valid tied 0 -> resp0_valid and resp0_err = 1 with result 0 after TIMEOUT WAIT cycles.
